// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush scheduler for the five-stage F/D/E/M/W pipeline.
// Merges the memory waits, the load-use bubble, branch redirects and
// serializing instructions into per-stage hold/kill controls.
// Ports:
//   clk, reset (async, active-low)
//   ireq_wait, dreq_wait            imem/dmem wait
//   bubble_d, branch_e, serial_d    decode hazard, E redirect, serializing op in D
//   valid_e, valid_m, valid_w       back-end occupancy
//   retire_serial                   serializing op commits in W
//   stopf, stopd, stope, stopm      per-stage holds
//   flush_d, bubble_e               kill F->D, insert bubble into D->E
//   busy, err_timeout               serialization in progress, sticky dmem watchdog
// Optional macro PIPE_CTRL_PERF_EN adds stall_cnt, flush_cnt and serial_cnt.
module pipe_ctrl #(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic ireq_wait,
    input  logic dreq_wait,
    input  logic bubble_d,
    input  logic branch_e,
    input  logic serial_d,
    input  logic valid_e,
    input  logic valid_m,
    input  logic valid_w,
    input  logic retire_serial,
    output logic stopf,
    output logic stopd,
    output logic stope,
    output logic stopm,
    output logic flush_d,
    output logic bubble_e,
    output logic busy,
    output logic err_timeout
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] serial_cnt
`endif
);
    typedef enum logic [1:0] {RUN, DRAIN, ISSUE, WAIT_RET} state_t;
    localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT_CYC);
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic err_q, err_d;
    logic hold_d, in_run;
    always_comb begin
        in_run   = state_q == RUN;
        // A serializing op seen in RUN is held in D at once so it cannot slip
        // into E before the back end has drained.
        hold_d   = bubble_d | (in_run & serial_d) | state_q == DRAIN;
        stopf    = !reset ? 1'b0 : dreq_wait ? 1'b1 : branch_e ? 1'b0 : ireq_wait | hold_d | !in_run;
        stopd    = !reset ? 1'b0 : dreq_wait ? 1'b1 : branch_e ? 1'b0 : hold_d;
        stope    = reset & dreq_wait;
        stopm    = reset & dreq_wait;
        // An ireq_wait kill is suppressed while D is held, so a held op is never lost.
        flush_d  = !reset ? 1'b1 : dreq_wait ? 1'b0 : branch_e ? 1'b1 :
                   (ireq_wait & !hold_d) | state_q == ISSUE | state_q == WAIT_RET;
        bubble_e = !reset ? 1'b1 : dreq_wait ? 1'b0 : branch_e ? 1'b1 : hold_d;
        busy     = reset & !in_run;
        state_d  = (state_q == WAIT_RET && retire_serial) ? RUN :
                   dreq_wait ? state_q :
                   branch_e ? (state_q == WAIT_RET ? WAIT_RET : RUN) :
                   in_run ? ((serial_d & !ireq_wait & !bubble_d) ? DRAIN : RUN) :
                   state_q == DRAIN ? ((valid_e | valid_m | valid_w) ? DRAIN : ISSUE) :
                   WAIT_RET;
        cnt_d    = !dreq_wait ? '0 : cnt_q == TO ? cnt_q : cnt_q + CNT_W'(1);
        err_d    = err_q | (dreq_wait & cnt_d == TO);
    end
    assign err_timeout = err_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end
`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            serial_cnt <= '0;
        end else begin
            stall_cnt  <= stall_cnt + CNT_W'(stopf);
            flush_cnt  <= flush_cnt + CNT_W'(branch_e & !dreq_wait);
            serial_cnt <= serial_cnt + CNT_W'(state_q == WAIT_RET && state_d == RUN);
        end
    end
`endif
endmodule
